idu_queue: RTL
==============

// Module: idu_queue
// PURPOSE
//  Parametrised decode stage for the OoO core: buffers fetched {pc,inst} in a DEPTH-entry circular queue and decodes the head entry.
//  Presents the decoded micro-op to dispatch over a valid/ready handshake. Sits between fetch and rename/dispatch.
//  Supports full back-pressure and whole-queue flush on mispredict or exception.
// PARAMETERS
//  DEPTH   8   queue entries; power of 2, >=2
//  XLEN    32  pc/inst/imm width; only 32 is supported
// PORTS
//  clk_i            in   1     clock; all state changes on posedge
//  rst_n_i          in   1     synchronous active-low reset
//  fetch_valid_i    in   1     fetch presents an instruction
//  fetch_ready_o    out  1     queue can accept; = (count < DEPTH)
//  fetch_pc_i       in   XLEN  pc of fetched inst
//  fetch_inst_i     in   32    raw instruction word
//  flush_i          in   1     discard all queued entries
//  dec_valid_o      out  1     head entry valid; = (count != 0)
//  dec_ready_i      in   1     dispatch accepts head
//  dec_pc_o         out  XLEN  head pc
//  dec_inst_o       out  32    head raw instruction
//  dec_uop_o        out  3     uop_class_t of head
//  dec_aluop_o      out  4     ALU op, rv32i_types encoding
//  dec_rs1_o/rs2_o  out  5     source regs; forced 0 when the format has none
//  dec_rd_o         out  5     destination reg
//  dec_rd_wr_o      out  1     writes rd; 0 when rd==x0 or illegal
//  dec_imm_o        out  XLEN  sign-extended immediate for the format
//  dec_use_imm_o    out  1     ALU operand B is the immediate
//  dec_illegal_o    out  1     opcode not RV32I
//  count_o          out  $clog2(DEPTH)+1  occupancy
//  redirect_o       out  1     (IDU_JAL_REDIRECT_EN only) pulse, decode-time JAL redirect
//  redirect_pc_o    out  XLEN  (IDU_JAL_REDIRECT_EN only) JAL target
// BEHAVIOUR
//  Reset (rst_n_i==0 at posedge): wr_ptr=rd_ptr=count=0, so dec_valid_o=0, fetch_ready_o=1, count_o=0. Entry storage is not reset.
//  Push when fetch_valid_i&&fetch_ready_o; pop when dec_valid_o&&dec_ready_i. Both may occur in one cycle; count is then unchanged.
//  Full: fetch_ready_o=0 even if a pop occurs that cycle (no same-cycle pass-through).
//  Latency: an inst pushed at edge N is visible on dec_* after edge N, at the earliest; queue-empty bypass is not provided.
//  Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally. Queue order is strictly FIFO.
//  dec_* outputs are combinational from the head entry. They are don't-care when dec_valid_o=0.
//  flush_i has priority over push and pop: pointers and count go to 0 at the edge; any push or pop that cycle is discarded.
//  Decode fields:
//   lui/auipc: imm=U, aluop=add.
//   jal: imm=J. jalr: imm=I.
//   br: imm=B, rd_wr=0.
//   load: imm=I, use_imm=1.
//   store: imm=S, rd_wr=0.
//   op-imm/op: aluop uses funct3, with funct7[5] selecting sub/sra.
//   Any other opcode: illegal=1, rd_wr=0, uop=UOP_ALU.
// CONFIGURATION
//  `IDU_JAL_REDIRECT_EN defined:
//   - On a head pop of a JAL: redirect_o=1 and redirect_pc_o=pc+J-imm in the same cycle.
//   - At that edge all younger entries and any same-cycle push are discarded; count becomes 0.
//   - The JAL itself is still dispatched, so it can write rd.
//  Not defined: redirect ports are absent; JAL is dispatched like a branch and the queue is untouched.
// STRUCTURE
//  Package rv32i_types (shared): opcode and funct3 constants, alu_op enum, and new uop_class_t:
//   {UOP_ALU, UOP_BR, UOP_JAL, UOP_JALR, UOP_LD, UOP_ST, UOP_LUI, UOP_AUIPC}.
//  The package also holds the queue entry struct iq_entry_t {pc, inst}.
//  One sub-module, rv32i_decoder: purely combinational inst -> decoded fields. It is reused by later front-end stages.
// TESTING
//  1. Reset, push 0x00500093 (addi x1,x0,5) at pc 0x1000 -> next cycle: dec_valid_o=1, uop=ALU, rd=1, imm=5, use_imm=1, count_o=1.
//  2. Push DEPTH insts with dec_ready_i=0 -> fetch_ready_o=0 and count_o=DEPTH. Pop+push in the same cycle -> push refused.
//     Drain all entries -> original order; pointers wrap correctly.
//  3. Push 0x402081B3 (sub x3,x1,x2) -> aluop=sub, rs1=1, rs2=2, rd=3, use_imm=0.
//     Push 0x0020A423 (sw) -> uop=ST, imm=8, rd_wr=0.
//     Push 0x0040A103 (lw) -> uop=LD, imm=4, rd=2.
//  4. Queue holds 3 entries; flush_i=1 with simultaneous push and pop -> count_o=0 and dec_valid_o=0 next cycle.
//     The next push is then seen first.
//  5. With EN: push 0x008000EF (jal x1,+8) at pc 0x2000, then 2 more entries, then pop the JAL ->
//     redirect_o=1, redirect_pc_o=0x2008, count_o=0 next cycle.
//     Without EN: same sequence -> count_o=2.
//  6. Push 0x0000007F -> dec_illegal_o=1, dec_rd_wr_o=0. Assert rst_n_i=0 mid-stream -> count_o=0 and fetch_ready_o=1.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_types : shared RV32I front-end types
//
// Purpose
//   Opcode and funct3 constants, the ALU operation enum, the micro-op class
//   enum and the decode-queue entry struct. Shared by the decode queue and by
//   any later front-end stage that reuses the decoder.
//
// Contents
//   XLEN_C          native register/pc width (32)
//   OPC_*           7-bit major opcodes of the RV32I base set
//   F3_*            funct3 values for OP / OP-IMM
//   alu_op_t        4-bit ALU operation encoding
//   uop_class_t     3-bit micro-op class handed to dispatch
//   iq_entry_t      one queue slot: {pc, inst}
//   aluFromFunct3   funct3/funct7[5] -> alu_op_t
// ----------------------------------------------------------------------------
package rv32i_types;

    localparam int XLEN_C = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        UOP_ALU   = 3'd0,
        UOP_BR    = 3'd1,
        UOP_JAL   = 3'd2,
        UOP_JALR  = 3'd3,
        UOP_LD    = 3'd4,
        UOP_ST    = 3'd5,
        UOP_LUI   = 3'd6,
        UOP_AUIPC = 3'd7
    } uop_class_t;

    typedef struct packed {
        logic [XLEN_C-1:0] pc;
        logic [31:0]       inst;
    } iq_entry_t;

    // funct7[5] only matters for the add/sub and srl/sra pairs. Immediate
    // forms never subtract: on ADDI that bit belongs to the immediate.
    function automatic alu_op_t aluFromFunct3(input logic [2:0] f3,
                                              input logic       alt,
                                              input logic       isReg);
        alu_op_t result;
        case (f3)
            F3_ADDSUB: result = (alt && isReg) ? ALU_SUB : ALU_ADD;
            F3_SLL:    result = ALU_SLL;
            F3_SLT:    result = ALU_SLT;
            F3_SLTU:   result = ALU_SLTU;
            F3_XOR:    result = ALU_XOR;
            F3_SR:     result = alt ? ALU_SRA : ALU_SRL;
            F3_OR:     result = ALU_OR;
            default:   result = ALU_AND;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/idu_queue_decoder.sv
// ----------------------------------------------------------------------------
// rv32i_decoder : purely combinational RV32I instruction decoder
//
// Purpose
//   Splits one raw instruction word into the fields dispatch needs. No state,
//   so it can be dropped into any front-end stage.
//
// Ports
//   i_inst      in   32  raw instruction word
//   o_uop       out  3   micro-op class
//   o_aluop     out  4   ALU operation
//   o_rs1/rs2   out  5   source registers, 0 when the format has none
//   o_rd        out  5   destination register, 0 when the format has none
//   o_rdWr      out  1   writes rd (never for x0, stores, branches, illegal)
//   o_imm       out  32  sign-extended immediate of the format
//   o_useImm    out  1   ALU operand B is the immediate
//   o_illegal   out  1   opcode outside the supported RV32I set
// ----------------------------------------------------------------------------
module rv32i_decoder
    import rv32i_types::*;
(
    input  logic [31:0] i_inst,
    output uop_class_t  o_uop,
    output alu_op_t     o_aluop,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic        o_rdWr,
    output logic [31:0] o_imm,
    output logic        o_useImm,
    output logic        o_illegal
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_funct7b5;
    logic [31:0] w_immI;
    logic [31:0] w_immS;
    logic [31:0] w_immB;
    logic [31:0] w_immU;
    logic [31:0] w_immJ;
    logic        w_hasRd;

    assign w_opcode   = i_inst[6:0];
    assign w_funct3   = i_inst[14:12];
    assign w_funct7b5 = i_inst[30];

    // Immediate formats; bit 0 of B and J is always zero.
    assign w_immI = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_immS = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_immB = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_immU = {i_inst[31:12], 12'h000};
    assign w_immJ = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    // Per-opcode field selection. Register fields default to 0 so that
    // formats without rs1/rs2/rd present clean zeros to rename.
    always_comb begin
        o_uop     = UOP_ALU;
        o_aluop   = ALU_ADD;
        o_rs1     = 5'd0;
        o_rs2     = 5'd0;
        o_imm     = 32'h0;
        o_useImm  = 1'b0;
        o_illegal = 1'b0;
        w_hasRd   = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                o_uop    = UOP_LUI;
                o_imm    = w_immU;
                o_useImm = 1'b1;
                w_hasRd  = 1'b1;
            end
            OPC_AUIPC: begin
                o_uop    = UOP_AUIPC;
                o_imm    = w_immU;
                o_useImm = 1'b1;
                w_hasRd  = 1'b1;
            end
            OPC_JAL: begin
                o_uop   = UOP_JAL;
                o_imm   = w_immJ;
                w_hasRd = 1'b1;
            end
            OPC_JALR: begin
                o_uop    = UOP_JALR;
                o_imm    = w_immI;
                o_rs1    = i_inst[19:15];
                o_useImm = 1'b1;
                w_hasRd  = 1'b1;
            end
            OPC_BRANCH: begin
                o_uop = UOP_BR;
                o_imm = w_immB;
                o_rs1 = i_inst[19:15];
                o_rs2 = i_inst[24:20];
            end
            OPC_LOAD: begin
                o_uop    = UOP_LD;
                o_imm    = w_immI;
                o_rs1    = i_inst[19:15];
                o_useImm = 1'b1;
                w_hasRd  = 1'b1;
            end
            OPC_STORE: begin
                o_uop    = UOP_ST;
                o_imm    = w_immS;
                o_rs1    = i_inst[19:15];
                o_rs2    = i_inst[24:20];
                o_useImm = 1'b1;
            end
            OPC_OPIMM: begin
                o_aluop  = aluFromFunct3(w_funct3, w_funct7b5, 1'b0);
                o_imm    = w_immI;
                o_rs1    = i_inst[19:15];
                o_useImm = 1'b1;
                w_hasRd  = 1'b1;
            end
            OPC_OP: begin
                o_aluop = aluFromFunct3(w_funct3, w_funct7b5, 1'b1);
                o_rs1   = i_inst[19:15];
                o_rs2   = i_inst[24:20];
                w_hasRd = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

    assign o_rd   = w_hasRd ? i_inst[11:7] : 5'd0;
    assign o_rdWr = w_hasRd && (i_inst[11:7] != 5'd0);

endmodule

// File: rtl/idu_queue.sv
// ----------------------------------------------------------------------------
// idu_queue : decode stage of the OoO front end
//
// Purpose
//   Buffers fetched {pc, inst} pairs in a DEPTH-entry circular FIFO and
//   decodes the head entry for rename/dispatch over a valid/ready handshake.
//   Whole-queue flush on mispredict or exception.
//
// Parameters
//   DEPTH  queue entries, power of 2 and >= 2 (pointers wrap by overflow)
//   XLEN   pc/imm width, must be 32
//
// Ports
//   clk_i / rst_n_i        clock, synchronous active-low reset
//   fetch_valid_i/ready_o  fetch handshake; ready = (count < DEPTH)
//   fetch_pc_i/inst_i      incoming pc and raw instruction
//   flush_i                discard every queued entry (beats push and pop)
//   dec_valid_o/ready_i    dispatch handshake; valid = (count != 0)
//   dec_pc_o/inst_o        head pc and raw instruction
//   dec_uop_o .. dec_illegal_o  decoded head fields (see rv32i_decoder)
//   count_o                occupancy
//   redirect_o/pc_o        decode-time JAL redirect (only with macro below)
//
// Build option
//   IDU_JAL_REDIRECT_EN : popping a JAL from the head pulses redirect_o with
//   pc + J-imm and empties the queue (younger entries and any same-cycle push
//   are wrong-path). Without it the redirect ports do not exist and a JAL is
//   dispatched like any other instruction.
// ----------------------------------------------------------------------------
module idu_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   fetch_valid_i,
    output logic                   fetch_ready_o,
    input  logic [XLEN-1:0]        fetch_pc_i,
    input  logic [31:0]            fetch_inst_i,
    input  logic                   flush_i,
    output logic                   dec_valid_o,
    input  logic                   dec_ready_i,
    output logic [XLEN-1:0]        dec_pc_o,
    output logic [31:0]            dec_inst_o,
    output uop_class_t             dec_uop_o,
    output alu_op_t                dec_aluop_o,
    output logic [4:0]             dec_rs1_o,
    output logic [4:0]             dec_rs2_o,
    output logic [4:0]             dec_rd_o,
    output logic                   dec_rd_wr_o,
    output logic [XLEN-1:0]        dec_imm_o,
    output logic                   dec_use_imm_o,
    output logic                   dec_illegal_o,
    output logic [$clog2(DEPTH):0] count_o
`ifdef IDU_JAL_REDIRECT_EN
    ,
    output logic                   redirect_o,
    output logic [XLEN-1:0]        redirect_pc_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    iq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    logic       w_push;
    logic       w_pop;
    logic       w_redirect;
    iq_entry_t  w_head;
    uop_class_t w_uop;
    logic [31:0] w_imm;

    // Ready depends on occupancy only: a full queue refuses a push even when
    // dispatch drains the head in the same cycle.
    assign fetch_ready_o = (r_count < CNT_W'(DEPTH));
    assign dec_valid_o   = (r_count != '0);
    assign w_push        = fetch_valid_i && fetch_ready_o;
    assign w_pop         = dec_valid_o && dec_ready_i;
    assign count_o       = r_count;

    assign w_head     = r_mem[r_rdPtr];
    assign dec_pc_o   = w_head.pc;
    assign dec_inst_o = w_head.inst;
    assign dec_uop_o  = w_uop;
    assign dec_imm_o  = w_imm;

    rv32i_decoder u_decoder (
        .i_inst    (w_head.inst),
        .o_uop     (w_uop),
        .o_aluop   (dec_aluop_o),
        .o_rs1     (dec_rs1_o),
        .o_rs2     (dec_rs2_o),
        .o_rd      (dec_rd_o),
        .o_rdWr    (dec_rd_wr_o),
        .o_imm     (w_imm),
        .o_useImm  (dec_use_imm_o),
        .o_illegal (dec_illegal_o)
    );

`ifdef IDU_JAL_REDIRECT_EN
    // The JAL target is fully known at decode, so the front end is steered
    // as soon as the JAL leaves the queue.
    assign w_redirect    = w_pop && (w_uop == UOP_JAL);
    assign redirect_o    = w_redirect;
    assign redirect_pc_o = w_head.pc + w_imm;
`else
    assign w_redirect = 1'b0;
`endif

    // Entry storage carries no reset: entries are only observed through the
    // pointers, which are reset. Writing a slot during flush is harmless.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= '{pc: fetch_pc_i, inst: fetch_inst_i};
        end
    end

    // Pointer and occupancy bookkeeping. Flush and redirect both empty the
    // queue and override whatever push/pop happened in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush_i || w_redirect) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
